// File: rtl/fifo_reader.sv
// FIFO read-side master with a small skid buffer feeding a valid/ready stream.
// Optional statistics counters are built when FIFO_READER_STATS_EN is defined.
module fifo_reader #(
  parameter int WIDTH      = 32,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  output logic                 fifo_rd_en,
  input  logic                 fifo_rd_valid,
  input  logic [WIDTH-1:0]     fifo_rd_data,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] pop_count,
  output logic [CNT_WIDTH-1:0] empty_stall_cnt
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);

  logic [WIDTH-1:0] entry [SKID_DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // rd_en depends only on state and flush, keeping out_ready off the FIFO path
  assign fifo_rd_en = !flush && (count != CW'(SKID_DEPTH));
  assign push       = fifo_rd_en && fifo_rd_valid;
  assign out_valid  = (count != '0) && !flush;
  assign out_data   = entry[head];
  assign pop        = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
    end
  end

  always_ff @(posedge clock) begin
    if (push) entry[tail] <= fifo_rd_data;
  end

`ifdef FIFO_READER_STATS_EN
  logic [CNT_WIDTH-1:0] pop_q;
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      pop_q   <= '0;
      stall_q <= '0;
    end else begin
      if (pop && (pop_q != '1))
        pop_q <= pop_q + 1'b1;
      if (fifo_rd_en && !fifo_rd_valid && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign pop_count       = pop_q;
  assign empty_stall_cnt = stall_q;
`else
  assign pop_count       = '0;
  assign empty_stall_cnt = '0;
`endif

endmodule
